// File: rtl/knight_pkg.sv
// Shared types and constants for the knight's tour checker and the tour solver.
package knight_pkg;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    RANGE        = 3'd1,
    REVISIT      = 3'd2,
    ILLEGAL_MOVE = 3'd3,
    NOT_CLOSED   = 3'd4
  } err_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // The eight knight offsets as (dx, dy) pairs, index-aligned.
  localparam logic signed [2:0] KNIGHT_DX [8] = '{3'sd1, 3'sd2, 3'sd2, 3'sd1,
                                                  -3'sd1, -3'sd2, -3'sd2, -3'sd1};
  localparam logic signed [2:0] KNIGHT_DY [8] = '{3'sd2, 3'sd1, -3'sd1, -3'sd2,
                                                  -3'sd2, -3'sd1, 3'sd1, 3'sd2};

endpackage

// File: rtl/knight_tour_checker_if.sv
// Square stream between a tour source (master) and the checker (slave).
// A square transfers on a rising edge where sq_valid && sq_ready; the master holds
// sq_x/sq_y stable while sq_valid is high, and sq_ready never depends on sq_valid.
interface knight_tour_checker_if;
  logic       sq_valid;
  logic [4:0] sq_x;
  logic [4:0] sq_y;
  logic       sq_ready;

  modport master (output sq_valid, output sq_x, output sq_y, input sq_ready);
  modport slave  (input sq_valid, input sq_x, input sq_y, output sq_ready);
endinterface

// File: rtl/knight_move_check.sv
// Combinational check that (ax,ay) -> (bx,by) is a single knight move.
module knight_move_check
  import knight_pkg::*;
(
  input  logic [4:0] ax,
  input  logic [4:0] ay,
  input  logic [4:0] bx,
  input  logic [4:0] by,
  output logic       legal
);

  localparam logic [5:0] STEP_S = 6'(KNIGHT_DY[1]);
  localparam logic [5:0] STEP_L = 6'(KNIGHT_DX[1]);

  logic signed [5:0] dx;
  logic signed [5:0] dy;
  logic [5:0]        adx;
  logic [5:0]        ady;

  assign dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign adx = dx[5] ? 6'(-dx) : 6'(dx);
  assign ady = dy[5] ? 6'(-dy) : 6'(dy);

  assign legal = ((adx == STEP_S) && (ady == STEP_L)) ||
                 ((adx == STEP_L) && (ady == STEP_S));

endmodule

// File: rtl/knight_tour_checker.sv
// Streams a proposed knight's tour and reports pass/fail with an error cause.
// Define KNIGHT_CLOSED_TOUR_EN to also require the last square to reach the first.
module knight_tour_checker
  import knight_pkg::*;
#(
  parameter int DIM = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  knight_tour_checker_if.slave sq,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2:0]           err_code,
  output logic [6:0]           step_cnt,
  output logic [1:0]           state_dbg
);

  localparam int         CELLS  = DIM * DIM;
  localparam logic [6:0] CELLS7 = 7'(CELLS);
  localparam logic [4:0] DIM5   = 5'(DIM);

  chk_state_t       state;
  err_t             err_q;
  logic [CELLS-1:0] visited;
  logic [4:0]       last_x;
  logic [4:0]       last_y;

  logic             accept;
  logic             in_range;
  logic [6:0]       idx;
  logic [CELLS-1:0] onehot;
  logic             hit;
  logic             move_ok;
  logic [6:0]       step_next;

  assign sq.sq_ready = (state == FIRST) || (state == RUN);
  assign busy        = sq.sq_ready;
  assign done        = (state == DONE);
  assign err_code    = err_q;
  assign state_dbg   = state;

  assign accept    = sq.sq_valid && sq.sq_ready;
  assign in_range  = (sq.sq_x < DIM5) && (sq.sq_y < DIM5);
  assign idx       = 7'(DIM) * {2'b00, sq.sq_x} + {2'b00, sq.sq_y};
  // Out-of-range squares never select a visited bit.
  assign onehot    = in_range ? ({{(CELLS-1){1'b0}}, 1'b1} << idx) : '0;
  assign hit       = |(visited & onehot);
  assign step_next = step_cnt + 7'd1;

  knight_move_check u_move (
    .ax   (sq.sq_x),
    .ay   (sq.sq_y),
    .bx   (last_x),
    .by   (last_y),
    .legal(move_ok)
  );

`ifdef KNIGHT_CLOSED_TOUR_EN
  logic [4:0] first_x;
  logic [4:0] first_y;
  logic       closed_ok;

  knight_move_check u_close (
    .ax   (sq.sq_x),
    .ay   (sq.sq_y),
    .bx   (first_x),
    .by   (first_y),
    .legal(closed_ok)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      err_q    <= NONE;
      pass     <= 1'b0;
      step_cnt <= '0;
      visited  <= '0;
      last_x   <= '0;
      last_y   <= '0;
`ifdef KNIGHT_CLOSED_TOUR_EN
      first_x  <= '0;
      first_y  <= '0;
`endif
    end else if (start) begin
      // Start wins over any square offered in the same cycle.
      state    <= FIRST;
      err_q    <= NONE;
      pass     <= 1'b0;
      step_cnt <= '0;
      visited  <= '0;
      last_x   <= '0;
      last_y   <= '0;
`ifdef KNIGHT_CLOSED_TOUR_EN
      first_x  <= '0;
      first_y  <= '0;
`endif
    end else if (accept) begin
      if (!in_range) begin
        err_q <= RANGE;
        state <= DONE;
      end else if ((state == RUN) && hit) begin
        err_q <= REVISIT;
        state <= DONE;
      end else if ((state == RUN) && !move_ok) begin
        err_q <= ILLEGAL_MOVE;
        state <= DONE;
      end else begin
        visited  <= visited | onehot;
        last_x   <= sq.sq_x;
        last_y   <= sq.sq_y;
        step_cnt <= step_next;
        state    <= RUN;
`ifdef KNIGHT_CLOSED_TOUR_EN
        if (state == FIRST) begin
          first_x <= sq.sq_x;
          first_y <= sq.sq_y;
        end
`endif
        if (step_next == CELLS7) begin
          state <= DONE;
`ifdef KNIGHT_CLOSED_TOUR_EN
          if (closed_ok) pass <= 1'b1;
          else           err_q <= NOT_CLOSED;
`else
          pass  <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: doc/knight_tour_checker.md
# knight_tour_checker

Synthesizable checker that consumes a proposed knight's tour one square at a time on a DIM×DIM board and reports pass or fail with an error cause. It sits downstream of the tour solver, or any tour source, on a valid/ready square stream. It independently confirms that each square is on-board and unvisited, that each step is a legal knight move, and that all DIM*DIM squares are covered.

## Interface
- DIM, default 5: board edge length; legal range 5..11, so DIM*DIM fits in 7 bits.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous and active-high; one clock, no other reset.
- start  in  1  pulse that begins a new check; clears all state.
- sq_valid  in  1  the square on sq_x/sq_y is presented.
- sq_x  in  5  row of the square (unsigned).
- sq_y  in  5  column of the square (unsigned).
- sq_ready  out  1  checker accepts a square this cycle.
- busy  out  1  a check is in progress.
- done  out  1  verdict available; held until the next start.
- pass  out  1  tour valid; meaningful only while done=1.
- err_code  out  3  0 NONE, 1 RANGE, 2 REVISIT, 3 ILLEGAL_MOVE, 4 NOT_CLOSED.
- step_cnt  out  7  number of squares accepted and found legal.

## Operation
- FSM states: IDLE, FIRST, RUN, DONE. Reset → IDLE.
- IDLE: sq_ready=0; start → FIRST.
- FIRST: sq_ready=1. An accepted square (sq_valid&&sq_ready) is checked for range only.
  - Legal: set its visited bit, store it as both first and last square, step_cnt=1, go to RUN.
- RUN: sq_ready=1. Each accepted square goes through three checks, first failure wins:
  - RANGE: sq_x≥DIM or sq_y≥DIM.
  - REVISIT: the square's visited bit is already set.
  - ILLEGAL_MOVE: {|dx|,|dy|} relative to the last square is not {1,2} or {2,1}.
  - Pass: set visited bit, update last square, step_cnt+1.
  - When step_cnt reaches DIM*DIM, go to DONE with pass=1.
  - On any failure: go to DONE with pass=0 and err_code set; step_cnt keeps its last legal count.
- DONE: sq_ready=0, done=1; start → FIRST with all state cleared.
- start in FIRST/RUN aborts the current check and restarts in FIRST; any square offered that same cycle is ignored.
- Arithmetic rules:
  - dx and dy are computed as 6-bit signed differences; absolute values are compared against the constants 1 and 2.
  - visited bit index = DIM*sq_x+sq_y, computed only after the range check passes.
- A first square in FIRST always passes the move check.
- sq_valid with sq_ready=0 is ignored and has no side effects.

## Timing
- Reset values: sq_ready=0, busy=0, done=0, pass=0, err_code=0, step_cnt=0, visited=all 0, state IDLE.
- sq_ready is a decode of the registered state only; it has no combinational path from inputs.
- A square accepted at edge k is reflected in step_cnt/err_code/done after edge k. This gives 1-cycle verdict latency and 1 square/cycle throughput.
- After a terminating square, sq_ready is 0 in the very next cycle; no further square is consumed.
- busy=1 exactly in FIRST and RUN.
- rst asserted mid-check immediately forces every output to its reset value and the state to IDLE.

## Configuration
- KNIGHT_CLOSED_TOUR_EN defined: after the DIM*DIM-th square passes, the last square must also be a knight move from the first square.
  - Fails → DONE, pass=0, err_code=4.
  - Holds → pass=1.
  - Same cycle as the final acceptance; no extra latency.
- Undefined: open tours pass, err_code 4 is never produced, and the first-square register is not built.

## Structure
- Package knight_pkg holds:
  - typedef enum err_t (NONE, RANGE, REVISIT, ILLEGAL_MOVE, NOT_CLOSED).
  - typedef enum chk_state_t (IDLE, FIRST, RUN, DONE).
  - The eight knight-move offset constants, shared with the solver.
- One sub-module, knight_move_check: combinational; inputs are two 5-bit coordinate pairs, output is a legal-move flag. It is instantiated once, or twice with KNIGHT_CLOSED_TOUR_EN.

## Test plan
- DIM=5, start, feed the solver's open tour from (0,0), all 25 squares back-to-back → done=1, pass=1, err_code=0, step_cnt=25; sq_ready=0 the cycle after the last square.
- start, (0,0) then (1,1) → done=1, pass=0, err_code=3, step_cnt=1; a third square offered is not consumed.
- start, (0,0),(2,1),(0,0) → err_code=2, step_cnt=2.
- start, first square (5,0) → err_code=1, step_cnt=0; a valid stream with random sq_valid gaps of 0-3 cycles gives an identical verdict to back-to-back.
- Assert rst after 10 squares → all outputs 0 next sample; start during RUN after 7 squares restarts with step_cnt=0, and a full valid tour then passes.
- With KNIGHT_CLOSED_TOUR_EN, DIM=6: a closed tour gives pass=1; an open tour gives err_code=4, step_cnt=36.
